instr_encoder_loader: RTL and testbench

// Inverse of the main opcode decoder. Takes instruction requests as instruction class plus fields,

---
 rtl/instr_encoder_loader_if.sv | 40 ++++
 rtl/instr_encoder_loader.sv | 138 +++++++++++++
 tb/tb_instr_encoder_loader.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_loader_if.sv
// Bundle of the request channel, the instruction-memory write channel and the
// job status lines shared by the program loader and whatever drives it.
interface instr_encoder_loader_if #(
    parameter int AW = 32,
    parameter int CW = 8
);
    logic          start;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] n_instr;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    kind;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [5:0]    funct;
    logic [15:0]   imm;
    logic [25:0]   target;
    logic          imem_we;
    logic          imem_ready;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          busy;
    logic          done;
    logic          err;

    // The loader itself sits on the slave side.
    modport slave (
        input  start, base_addr, n_instr, in_valid, kind, rs, rt, rd, funct,
               imm, target, imem_ready,
        output in_ready, imem_we, imem_addr, imem_wdata, busy, done, err
    );

    // The host/memory side that feeds requests and absorbs writes.
    modport master (
        output start, base_addr, n_instr, in_valid, kind, rs, rt, rd, funct,
               imm, target, imem_ready,
        input  in_ready, imem_we, imem_addr, imem_wdata, busy, done, err
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Boot/program loader: encodes instruction requests (class + fields) into
// 32-bit MIPS words and streams them into instruction memory at consecutive
// word addresses. Only the classes the main decoder understands are encoded;
// anything else is swallowed and flagged through the sticky err line.
module instr_encoder_loader #(
    parameter int AW = 32,
    parameter int CW = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    instr_encoder_loader_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [AW-1:0] addr;
    logic [CW-1:0] rem;
    logic [CW-1:0] rem_acc;
    logic          we_q;
    logic [31:0]   wdata_q;
    logic          err_q;

    logic [5:0]    opcode;
    logic [31:0]   enc_word;
    logic          legal;
    logic          ready_int;
    logic          accept;
    logic          wr_done;

    // Map the request class to its opcode and pack the fields into R/I/J layout.
    always_comb begin
        opcode   = 6'b000000;
        enc_word = 32'h0000_0000;
        legal    = 1'b1;
        case (bus.kind)
            3'd0:    opcode = 6'b000000;
            3'd1:    opcode = 6'b100011;
            3'd2:    opcode = 6'b101011;
            3'd3:    opcode = 6'b000100;
            3'd4:    opcode = 6'b001000;
            3'd5:    opcode = 6'b000010;
            default: legal  = 1'b0;
        endcase
        case (bus.kind)
            3'd0:    enc_word = {opcode, bus.rs, bus.rt, bus.rd, 5'b00000, bus.funct};
            3'd5:    enc_word = {opcode, bus.target};
            default: enc_word = {opcode, bus.rs, bus.rt, bus.imm};
        endcase
    end

    // A write retires when memory takes it; a request is taken only while
    // legal words are still owed and the single output slot is free or freeing.
    assign wr_done = we_q & bus.imem_ready;
    assign accept  = bus.in_valid & ready_int;

    // Next-state and job-level status outputs.
    always_comb begin
        state_next = state;
        ready_int  = 1'b0;
        bus.busy   = (state != IDLE);
        bus.done   = (state == DONE);
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = (bus.n_instr == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                ready_int = (rem_acc != '0) && (!we_q || bus.imem_ready);
                if (wr_done && (rem == CW'(1))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        bus.in_ready = ready_int;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Job counters, the held output word and the sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr    <= '0;
            rem     <= '0;
            rem_acc <= '0;
            we_q    <= 1'b0;
            wdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else begin
            if ((state == IDLE) && bus.start) begin
                addr    <= {bus.base_addr[AW-1:2], 2'b00};
                rem     <= bus.n_instr;
                rem_acc <= bus.n_instr;
                we_q    <= 1'b0;
                err_q   <= 1'b0;
            end else if (state == RUN) begin
                if (accept && legal) begin
                    we_q    <= 1'b1;
                    wdata_q <= enc_word;
                    rem_acc <= rem_acc - CW'(1);
                end else if (wr_done) begin
                    we_q <= 1'b0;
                end
                if (accept && !legal) begin
                    err_q <= 1'b1;
                end
                if (wr_done) begin
                    addr <= addr + AW'(4);
                    rem  <= rem - CW'(1);
                end
            end
        end
    end

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr;
    assign bus.imem_wdata = wdata_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for the program loader: a driver issues jobs and pushes the
// expected memory writes, a free-running monitor pops and compares every write
// the loader completes.
module tb_instr_encoder_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;

    instr_encoder_loader_if bus ();

    instr_encoder_loader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  kind;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
    } req_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         sbQ[$];
    req_t        jobReqs[$];
    logic [31:0] dirExp[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lastWriteCyc = -10;
    int jobN = 0;
    int readyPct = 100;
    int gapMax = 0;
    bit readyForce = 1'b0;

    int opTab[6] = '{0, 35, 43, 4, 8, 2};

    // Compare one observed value against the bench's expectation.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding straight from the instruction formats.
    function automatic logic [31:0] encodeRef(input req_t r);
        logic [31:0] op;
        op = 32'(opTab[r.kind]) << 26;
        if (r.kind == 3'd0)
            return op | (32'(r.rs) << 21) | (32'(r.rt) << 16) | (32'(r.rd) << 11) | 32'(r.funct);
        else if (r.kind == 3'd5)
            return op | 32'(r.target);
        else
            return op | (32'(r.rs) << 21) | (32'(r.rt) << 16) | 32'(r.imm);
    endfunction

    function automatic void addReq(input logic [2:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                                   input logic [4:0] rd, input logic [5:0] funct,
                                   input logic [15:0] imm, input logic [25:0] target);
        req_t r;
        r.kind = kind; r.rs = rs; r.rt = rt; r.rd = rd;
        r.funct = funct; r.imm = imm; r.target = target;
        jobReqs.push_back(r);
    endfunction

    function automatic void addRandom(input logic [2:0] kind);
        addReq(kind, 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom),
               16'($urandom), 26'($urandom));
    endfunction

    // Memory side: accept writes with a configurable probability.
    initial begin
        bus.imem_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (!readyForce) bus.imem_ready = ($urandom_range(99) < readyPct);
        end
    end

    // Monitor: sample just before each rising edge, check held writes and
    // completed writes against the scoreboard, and time the done pulse.
    initial begin : monitor
        logic        stalledPrev;
        logic [31:0] heldAddr;
        logic [31:0] heldData;
        wr_t         e;
        stalledPrev = 1'b0;
        heldAddr = '0;
        heldData = '0;
        forever begin
            @(negedge clk);
            #4;
            cyc++;
            if (reset) begin
                stalledPrev = 1'b0;
            end else begin
                if (stalledPrev) begin
                    checkOutput("hold_we", 32'(bus.imem_we), 32'd1);
                    checkOutput("hold_addr", bus.imem_addr, heldAddr);
                    checkOutput("hold_data", bus.imem_wdata, heldData);
                end
                if (bus.imem_we && bus.imem_ready) begin
                    if (sbQ.size() == 0) begin
                        checkOutput("write_when_none_expected", 32'(bus.imem_we), 32'd0);
                    end else begin
                        e = sbQ.pop_front();
                        checkOutput("wr_addr", bus.imem_addr, e.addr);
                        checkOutput("wr_data", bus.imem_wdata, e.data);
                    end
                    lastWriteCyc = cyc;
                end
                stalledPrev = bus.imem_we && !bus.imem_ready;
                heldAddr = bus.imem_addr;
                heldData = bus.imem_wdata;
                if (bus.done) begin
                    checkOutput("done_sb_empty", 32'(sbQ.size()), 32'd0);
                    if (jobN != 0) checkOutput("done_latency", 32'(cyc - lastWriteCyc), 32'd1);
                end
            end
        end
    end

    // Run one job: queue expected writes, start, feed jobReqs, wait for done.
    task automatic applyStimulus(input logic [31:0] base, input int n, input logic expErr);
        int   k;
        int   waited;
        req_t r;
        wr_t  e;
        k = 0;
        foreach (jobReqs[i]) begin
            if (jobReqs[i].kind <= 3'd5) begin
                e.addr = (base & ~32'h3) + 32'(4 * k);
                e.data = (dirExp.size() > 0) ? dirExp.pop_front() : encodeRef(jobReqs[i]);
                sbQ.push_back(e);
                k++;
            end
        end
        jobN = n;
        @(negedge clk);
        bus.start = 1'b1;
        bus.base_addr = base;
        bus.n_instr = 8'(n);
        @(negedge clk);
        bus.start = 1'b0;
        bus.base_addr = $urandom;
        bus.n_instr = 8'($urandom);
        #4;
        checkOutput("err_after_start", 32'(bus.err), 32'd0);
        checkOutput("busy_after_start", 32'(bus.busy), 32'd1);
        if (n == 0) checkOutput("done_empty_job", 32'(bus.done), 32'd1);
        foreach (jobReqs[i]) begin
            repeat ($urandom_range(gapMax)) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                bus.start = 1'($urandom_range(1));
            end
            @(negedge clk);
            r = jobReqs[i];
            bus.kind = r.kind; bus.rs = r.rs; bus.rt = r.rt; bus.rd = r.rd;
            bus.funct = r.funct; bus.imm = r.imm; bus.target = r.target;
            bus.in_valid = 1'b1;
            bus.start = 1'($urandom_range(1));
            #4;
            waited = 0;
            while (!bus.in_ready && waited < 100) begin
                @(negedge clk);
                #4;
                waited++;
            end
            if (!bus.in_ready) checkOutput("accept_timeout", 32'(bus.in_ready), 32'd1);
        end
        if (n != 0) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.start = 1'b0;
            #4;
            waited = 0;
            while (!bus.done && waited < 300) begin
                @(negedge clk);
                #4;
                waited++;
            end
            if (!bus.done) checkOutput("done_timeout", 32'(bus.done), 32'd1);
        end
        @(negedge clk);
        #4;
        checkOutput("busy_after_done", 32'(bus.busy), 32'd0);
        checkOutput("done_one_cycle", 32'(bus.done), 32'd0);
        checkOutput("err_after_job", 32'(bus.err), 32'(expErr));
        checkOutput("all_writes_seen", 32'(sbQ.size()), 32'd0);
        jobReqs.delete();
    endtask

    // Directed and randomized jobs, then the summary.
    initial begin : driver
        int   n;
        logic hasIll;
        int   waited;
        bus.start = 1'b0; bus.base_addr = '0; bus.n_instr = '0; bus.in_valid = 1'b0;
        bus.kind = '0; bus.rs = '0; bus.rt = '0; bus.rd = '0;
        bus.funct = '0; bus.imm = '0; bus.target = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #4;
        checkOutput("rst_imem_we", 32'(bus.imem_we), 32'd0);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        checkOutput("rst_err", 32'(bus.err), 32'd0);
        checkOutput("rst_imem_addr", bus.imem_addr, 32'd0);
        checkOutput("rst_imem_wdata", bus.imem_wdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Boot example: ADDI, LW, J at 0x40.
        readyPct = 100; gapMax = 0;
        addReq(3'd4, 5'd0, 5'd8, 5'd0, 6'd0, 16'd5, 26'd0);
        addReq(3'd1, 5'd8, 5'd9, 5'd0, 6'd0, 16'd4, 26'd0);
        addReq(3'd5, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10);
        dirExp.push_back(32'h2008_0005);
        dirExp.push_back(32'h8D09_0004);
        dirExp.push_back(32'h0800_0010);
        applyStimulus(32'h0000_0040, 3, 1'b0);

        // RTYPE, SW with negative offset, BEQ back-branch.
        addReq(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 26'd0);
        addReq(3'd2, 5'd29, 5'd31, 5'd0, 6'd0, 16'hFFFC, 26'd0);
        addReq(3'd3, 5'd4, 5'd5, 5'd0, 6'd0, 16'hFFFF, 26'd0);
        dirExp.push_back(32'h0022_1820);
        dirExp.push_back(32'hAFBF_FFFC);
        dirExp.push_back(32'h1085_FFFF);
        applyStimulus(32'h0000_0100, 3, 1'b0);

        // Memory stalls for three cycles with a word pending mid-job.
        readyPct = 100; gapMax = 0;
        for (int i = 0; i < 4; i++) addRandom(3'($urandom_range(5)));
        fork
            applyStimulus(32'h0000_0200, 4, 1'b0);
            begin
                waited = 0;
                @(negedge clk);
                #4;
                while (!bus.imem_we && waited < 100) begin
                    @(negedge clk);
                    #4;
                    waited++;
                end
                if (!bus.imem_we) checkOutput("stall_wait_timeout", 32'(bus.imem_we), 32'd1);
                repeat (3) begin
                    @(negedge clk);
                    readyForce = 1'b1;
                    bus.imem_ready = 1'b0;
                    #4;
                    checkOutput("stall_in_ready", 32'(bus.in_ready), 32'd0);
                    checkOutput("stall_we", 32'(bus.imem_we), 32'd1);
                end
                @(negedge clk);
                readyForce = 1'b0;
                bus.imem_ready = 1'b1;
            end
        join

        // Illegal class between two legal ones, then an empty job clears err.
        readyPct = 80; gapMax = 1;
        addRandom(3'd4);
        addRandom(3'd6);
        addRandom(3'd0);
        applyStimulus(32'h0000_0300, 2, 1'b1);
        applyStimulus(32'h0000_0400, 0, 1'b0);

        // Unaligned base near the top of the address space wraps to zero.
        addRandom(3'd1);
        addRandom(3'd2);
        applyStimulus(32'hFFFF_FFFE, 2, 1'b0);

        // Reset while a write is pending, with start raised in the same cycle.
        readyForce = 1'b1;
        bus.imem_ready = 1'b0;
        jobN = 2;
        @(negedge clk);
        bus.start = 1'b1; bus.base_addr = 32'h500; bus.n_instr = 8'd2;
        @(negedge clk);
        bus.start = 1'b0;
        bus.kind = 3'd4; bus.in_valid = 1'b1;
        #4;
        waited = 0;
        while (!bus.in_ready && waited < 100) begin
            @(negedge clk);
            #4;
            waited++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #4;
        checkOutput("rst_mid_pending_we", 32'(bus.imem_we), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        bus.start = 1'b1; bus.n_instr = 8'd3;
        @(negedge clk);
        reset = 1'b0;
        bus.start = 1'b0;
        #4;
        checkOutput("rst_mid_we", 32'(bus.imem_we), 32'd0);
        checkOutput("rst_mid_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_mid_addr", bus.imem_addr, 32'd0);
        readyForce = 1'b0;
        readyPct = 100;
        repeat (5) @(negedge clk);
        #4;
        checkOutput("rst_mid_still_idle", 32'(bus.busy), 32'd0);

        // Randomized jobs.
        repeat (20) begin
            readyPct = int'($urandom_range(100, 40));
            gapMax = int'($urandom_range(2));
            n = int'($urandom_range(6));
            hasIll = 1'b0;
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(4) == 0) begin
                    addRandom(3'($urandom_range(7, 6)));
                    hasIll = 1'b1;
                end
                addRandom(3'($urandom_range(5)));
            end
            applyStimulus($urandom, n, hasIll);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
